sobel_window_reader: RTL and testbench

SOBEL_WINDOW_READER -- requirements
Module: sobel_window_reader

---
 rtl/sobel_window_reader.sv | 140 ++++++++++++++
 tb/tb_sobel_window_reader.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/sobel_window_reader.sv
// Streams every interior 3x3 window of an IMG_W x IMG_H image out of a
// single-port pixel RAM (one-cycle read latency) with a valid/ready handshake.
module sobel_window_reader #(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int ADDR_W = 10,
  parameter int PIX_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic                 mem_rd_en,
  input  logic [PIX_W-1:0]     mem_rdata,
  output logic [9*PIX_W-1:0]   win_data,
  output logic [ADDR_W-1:0]    win_center,
  output logic                 win_valid,
  input  logic                 win_ready,
  output logic                 busy,
  output logic                 done
);

  localparam int                COL_W    = $clog2(IMG_W);
  localparam logic [ADDR_W-1:0] W_A      = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] FIRST_C  = ADDR_W'(IMG_W + 1);
  localparam logic [ADDR_W-1:0] LAST_C   = ADDR_W'(IMG_W * (IMG_H - 2) + IMG_W - 2);
  localparam logic [COL_W-1:0]  LAST_COL = COL_W'(IMG_W - 2);

  typedef enum logic [2:0] {IDLE, READ, WAIT, OUT, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] centre;
  logic [COL_W-1:0]  col;
  logic [3:0]        idx;
  logic [PIX_W-1:0]  win_reg [9];
  logic [ADDR_W-1:0] next_centre;
  logic [COL_W-1:0]  next_col;

  // Tap k of the window around centre c, row-major from top-left.
  function automatic logic [ADDR_W-1:0] tap_addr(input logic [ADDR_W-1:0] c,
                                                 input logic [3:0]        k);
    logic [ADDR_W-1:0] row;
    case (k)
      4'd0, 4'd1, 4'd2: row = c - W_A;
      4'd3, 4'd4, 4'd5: row = c;
      default:          row = c + W_A;
    endcase
    case (k)
      4'd0, 4'd3, 4'd6: return row - ADDR_W'(1);
      4'd2, 4'd5, 4'd8: return row + ADDR_W'(1);
      default:          return row;
    endcase
  endfunction

  // Skipping the right border of one row and the left border of the next is +3.
  always_comb begin
    next_centre = centre + ADDR_W'(1);
    next_col    = col + COL_W'(1);
    if (col == LAST_COL) begin
      next_centre = centre + ADDR_W'(3);
      next_col    = COL_W'(1);
    end
  end

  always_comb begin
    win_data = '0;
    for (int k = 0; k < 9; k++) win_data[k*PIX_W +: PIX_W] = win_reg[k];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      centre     <= '0;
      col        <= '0;
      idx        <= '0;
      mem_addr   <= '0;
      mem_rd_en  <= 1'b0;
      win_center <= '0;
      win_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      for (int k = 0; k < 9; k++) win_reg[k] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= READ;
            centre    <= FIRST_C;
            col       <= COL_W'(1);
            idx       <= 4'd0;
            mem_addr  <= tap_addr(FIRST_C, 4'd0);
            mem_rd_en <= 1'b1;
            busy      <= 1'b1;
          end
        end
        READ: begin
          // Data arriving now belongs to the address issued one cycle earlier.
          if (idx != 4'd0) win_reg[idx - 4'd1] <= mem_rdata;
          if (idx == 4'd8) begin
            state     <= WAIT;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
          end else begin
            idx      <= idx + 4'd1;
            mem_addr <= tap_addr(centre, idx + 4'd1);
          end
        end
        WAIT: begin
          win_reg[8] <= mem_rdata;
          win_center <= centre;
          win_valid  <= 1'b1;
          state      <= OUT;
        end
        OUT: begin
          if (win_ready) begin
            win_valid <= 1'b0;
            if (centre == LAST_C) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              centre    <= next_centre;
              col       <= next_col;
              idx       <= 4'd0;
              mem_addr  <= tap_addr(next_centre, 4'd0);
              mem_rd_en <= 1'b1;
              state     <= READ;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_window_reader.sv
// Self-checking bench for sobel_window_reader: a RAM model plus a queue-based
// reference of interior windows and their read addresses.
module tb_sobel_window_reader;
  localparam int IMG_W = 32, IMG_H = 32, ADDR_W = 10, PIX_W = 8, NPIX = IMG_W * IMG_H;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic                win_ready = 1'b0;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_rd_en;
  logic [PIX_W-1:0]    mem_rdata;
  logic [9*PIX_W-1:0]  win_data;
  logic [ADDR_W-1:0]   win_center;
  logic                win_valid, busy, done;

  logic [PIX_W-1:0]    mem [NPIX];
  int                  checks = 0;
  int                  failures = 0;

  int                  exp_center_q[$];
  logic [9*PIX_W-1:0]  exp_data_q[$];
  int                  exp_addr_q[$];

  sobel_window_reader #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .PIX_W(PIX_W)) dut (
    .clk(clk), .rst(rst), .start(start), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
    .mem_rdata(mem_rdata), .win_data(win_data), .win_center(win_center),
    .win_valid(win_valid), .win_ready(win_ready), .busy(busy), .done(done));

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_rd_en"}, mem_rd_en, 0);
    chk({tag, "_data"}, win_data, 0);
    chk({tag, "_center"}, win_center, 0);
    chk({tag, "_valid"}, win_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // Interior centres in row-major order, each with its nine taps.
  task automatic build_model();
    logic [9*PIX_W-1:0] d;
    int ctr, a;
    exp_center_q.delete(); exp_data_q.delete(); exp_addr_q.delete();
    for (int r = 1; r <= IMG_H - 2; r++)
      for (int c = 1; c <= IMG_W - 2; c++) begin
        ctr = r * IMG_W + c;
        d = '0;
        for (int k = 0; k < 9; k++) begin
          a = ctr + (k / 3 - 1) * IMG_W + (k % 3 - 1);
          d[k*PIX_W +: PIX_W] = mem[a];
          exp_addr_q.push_back(a);
        end
        exp_center_q.push_back(ctr);
        exp_data_q.push_back(d);
      end
  endtask

  // mode 0: ready tied high, start quiet. mode 1: first window held 20 cycles,
  // random ready afterwards, random start pulses while busy.
  task automatic run_pass(input int mode, output int done_cyc, output int ntr, output int last_c);
    int cyc = 0, first_v = -1, hold = 0;
    bit fin = 0;
    logic pend = 0;
    logic [9*PIX_W-1:0] pd = '0;
    logic [ADDR_W-1:0]  pc = '0;
    done_cyc = -1; ntr = 0; last_c = -1;
    build_model();
    @(negedge clk);
    start = 1'b1;
    win_ready = (mode == 0);
    while (!fin && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      start = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (cyc <= 10) chk("rd_en_first_window", mem_rd_en, cyc <= 9);
      if (mem_rd_en) begin
        if (exp_addr_q.size() == 0) chk("rd_addr_extra", 1, 0);
        else chk("rd_addr", mem_addr, exp_addr_q.pop_front());
      end else chk("addr_idle", mem_addr, 0);
      if (win_valid && first_v < 0) begin
        first_v = cyc;
        chk("first_valid_cycle", cyc, 11);
      end
      if (pend) begin
        chk("hold_valid", win_valid, 1);
        chk("hold_data", win_data, pd);
        chk("hold_center", win_center, pc);
        chk("hold_no_read", mem_rd_en, 0);
      end
      if (mode == 0) win_ready = 1'b1;
      else begin
        if (win_valid && ntr == 0) hold++;
        win_ready = (ntr == 0) ? (hold > 20) : ($urandom_range(0, 3) != 0);
      end
      if (win_valid && win_ready) begin
        if (exp_center_q.size() == 0) chk("win_extra", 1, 0);
        else begin
          chk("win_center", win_center, exp_center_q.pop_front());
          chk("win_data", win_data, exp_data_q.pop_front());
        end
        ntr++;
        last_c = win_center;
        pend = 1'b0;
      end else begin
        pend = win_valid;
        pd = win_data;
        pc = win_center;
      end
      if (done) begin
        fin = 1;
        done_cyc = cyc;
        chk("done_transfers", ntr, 900);
        chk("busy_in_done", busy, 1);
        start = 1'b1;
      end else chk("busy_during_pass", busy, 1);
    end
    if (!fin) chk("pass_timeout", 0, 1);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_done", busy, 0);
    chk("done_one_cycle", done, 0);
    repeat (3) begin
      @(negedge clk);
      chk("stay_idle_busy", busy, 0);
      chk("stay_idle_rd_en", mem_rd_en, 0);
    end
    chk("addr_queue_empty", exp_addr_q.size(), 0);
  endtask

  initial begin
    int dc, nt, lc, cyc;
    bit seen;
    for (int a = 0; a < NPIX; a++) mem[a] = PIX_W'(a);

    // Reset: outputs cleared immediately and while start toggles.
    #1 chk_zero("rst_async");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = ~start;
      chk_zero("rst_hold");
    end
    @(negedge clk);
    start = 1'b0;
    rst = 1'b0;

    // Ramp image, backpressure on the first window, random ready/start.
    run_pass(1, dc, nt, lc);
    chk("p1_last_center", lc, 990);

    // Abort mid-pass while reading the window around centre 40.
    for (int a = 0; a < NPIX; a++) mem[a] = PIX_W'($urandom);
    @(negedge clk);
    start = 1'b1;
    win_ready = 1'b1;
    seen = 0;
    cyc = 0;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (win_valid && win_center == ADDR_W'(39)) seen = 1;
    end
    chk("abort_reached_39", seen, 1);
    repeat (3) @(negedge clk);
    chk("abort_in_read", mem_rd_en, 1);
    rst = 1'b1;
    #1 chk_zero("abort_async");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (30) begin
      @(negedge clk);
      chk("abort_no_valid", win_valid, 0);
      chk("abort_no_done", done, 0);
      chk("abort_not_busy", busy, 0);
    end

    // Random image, ready tied high: full-pass timing.
    run_pass(0, dc, nt, lc);
    chk("p2_cycles_to_done", dc, 9901);
    chk("p2_transfers", nt, 900);
    chk("p2_last_center", lc, 990);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
